// File: rtl/sub_pkg.sv
// Shared constants, generate/propagate type and prefix operator for the
// pipelined Kogge-Stone subtractor.
package sub_pkg;

    localparam int SUB_WIDTH = 16;
    localparam int SUB_LOG2W = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // The higher-order group absorbs the lower one.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level: each bit i >= DIST merges with bit i-DIST.
module ks_prefix_level
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int DIST  = 1
) (
    input  gp_t [WIDTH-1:0] i_gp,
    output gp_t [WIDTH-1:0] o_gp
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_merge
            assign o_gp[i] = gp_combine(i_gp[i], i_gp[i-DIST]);
        end else begin : g_pass
            assign o_gp[i] = i_gp[i];
        end
    end

endmodule

// File: rtl/subtractor16b_pipe.sv
// Three-stage A - B - bin subtractor built on a Kogge-Stone carry network.
// Define SUB16_SIGNED_OVF_EN to add the signed-overflow flag on ovf.
module subtractor16b_pipe
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int LOG2W = SUB_LOG2W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    localparam int L1 = (LOG2W + 1) / 2;

    logic                        w_adv;
    logic [3:1]                  r_vld_pipe;
    gp_t  [WIDTH-1:0]            w_gp0;
    logic [WIDTH-1:0]            w_hs;
    gp_t  [LOG2W:0][WIDTH-1:0]   w_lvl;
    logic [WIDTH-1:0]            w_gfin;
    logic [WIDTH-1:0]            w_c;
    logic [WIDTH-1:0]            w_sum;
    logic [WIDTH-1:0]            w_unused_p;

    gp_t  [WIDTH-1:0]            r_s1_gp;
    logic [WIDTH-1:0]            r_s1_hs;
    logic                        r_s1_cin;
    gp_t  [WIDTH-1:0]            r_s2_gp;
    logic [WIDTH-1:0]            r_s2_hs;
    logic                        r_s2_cin;
    logic [WIDTH:0]              r_d;

    assign w_adv     = out_ready | ~r_vld_pipe[3];
    assign in_ready  = w_adv;
    assign out_valid = r_vld_pipe[3];
    assign D         = r_d;

    // A - B - bin == A + ~B + ~bin; the carry-in is folded into bit 0's generate.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_gp0[i].g = A[i] & ~B[i];
            w_gp0[i].p = A[i] ^ ~B[i];
            w_hs[i]    = A[i] ^ ~B[i];
        end
        w_gp0[0].g = (A[0] & ~B[0]) | ((A[0] ^ ~B[0]) & ~bin);
    end

    assign w_lvl[0] = r_s1_gp;

    for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
        if (k == L1) begin : g_from_s2
            ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
                .i_gp (r_s2_gp),
                .o_gp (w_lvl[k+1])
            );
        end else begin : g_from_prev
            ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
                .i_gp (w_lvl[k]),
                .o_gp (w_lvl[k+1])
            );
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_gfin[i]     = w_lvl[LOG2W][i].g;
            w_unused_p[i] = w_lvl[LOG2W][i].p;
        end
    end

    assign w_c   = {w_gfin[WIDTH-2:0], r_s2_cin};
    assign w_sum = r_s2_hs ^ w_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_s1_gp    <= '0;
            r_s1_hs    <= '0;
            r_s1_cin   <= 1'b0;
            r_s2_gp    <= '0;
            r_s2_hs    <= '0;
            r_s2_cin   <= 1'b0;
            r_d        <= '0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[2:1], in_valid};
            r_s1_gp    <= w_gp0;
            r_s1_hs    <= w_hs;
            r_s1_cin   <= ~bin;
            r_s2_gp    <= w_lvl[L1];
            r_s2_hs    <= r_s1_hs;
            r_s2_cin   <= r_s1_cin;
            r_d        <= {~w_gfin[WIDTH-1], w_sum};
        end
    end

`ifdef SUB16_SIGNED_OVF_EN
    logic r_s1_amsb;
    logic r_s2_amsb;
    logic r_ovf;

    // Operand signs differ exactly when the half-sum MSB (a ^ ~b) is 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_amsb <= 1'b0;
            r_s2_amsb <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_adv) begin
            r_s1_amsb <= A[WIDTH-1];
            r_s2_amsb <= r_s1_amsb;
            r_ovf     <= ~r_s2_hs[WIDTH-1] & (w_sum[WIDTH-1] != r_s2_amsb);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_subtractor16b_pipe.sv
// Self-checking bench for subtractor16b_pipe against an arithmetic reference model.
module tb_subtractor16b_pipe;
    import sub_pkg::*;

    localparam int W = SUB_WIDTH;
`ifdef SUB16_SIGNED_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         bin = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic         ovf;
    logic [W:0]   D;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0] exp_q[$];
    logic       exp_ovf_q[$];

    logic       s_irdy, s_ovld, s_ovf;
    logic [W:0] s_d;

    subtractor16b_pipe #(.WIDTH(W), .LOG2W(SUB_LOG2W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_d(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
        longint ua, ub, r;
        ua = longint'(a);
        ub = longint'(b);
        r  = ua - ub - longint'(bi);
        return {(ua < ub + longint'(bi)), r[W-1:0]};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic bi);
        longint sa, sb, r, lim;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = sa - sb - longint'(bi);
        lim = longint'(1) << (W - 1);
        return OVF_ON && ((r >= lim) || (r < -lim));
    endfunction

    // Drive one cycle just after the rising edge, sample on the falling edge,
    // and log into the scoreboard any beat that will be accepted next edge.
    task automatic cyc(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input logic ordy, input logic rn);
        @(posedge clk);
        #1;
        rst_n = rn; in_valid = iv; A = a; B = b; bin = bi; out_ready = ordy;
        @(negedge clk);
        s_irdy = in_ready; s_ovld = out_valid; s_d = D; s_ovf = ovf;
        if (rn && iv && s_irdy) begin
            exp_q.push_back(ref_d(a, b, bi));
            exp_ovf_q.push_back(ref_ovf(a, b, bi));
        end
    endtask

    task automatic test_reset();
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ovld !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", s_ovld); end
        n_checks++;
        if (s_d !== '0) begin n_fail++; $display("FAIL reset_D got %h want 0", s_d); end
        n_checks++;
        if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", s_ovf); end
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (s_irdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", s_irdy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{16'h1234, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000};
        logic [W-1:0] tb[5] = '{16'h0034, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001};
        logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W:0]   td[5] = '{17'h01200, 17'h1FFFF, 17'h1FFFF, 17'h00000, 17'h07FFF};
        logic         to[5] = '{1'b0, 1'b0, 1'b0, 1'b0, OVF_ON};
        for (int v = 0; v < 5; v++) begin
            cyc(1'b1, ta[v], tb[v], tc[v], 1'b1, 1'b1);
            n_checks++;
            if (s_irdy !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got %0b want 1", v, s_irdy); end
            for (int k = 1; k <= 4; k++) begin
                cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
                n_checks++;
                if (s_ovld !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL dir%0d_latency edge %0d out_valid got %0b want %0b", v, k, s_ovld, (k == 3));
                end
                if (k == 3) begin
                    n_checks++;
                    if (s_d !== td[v]) begin n_fail++; $display("FAIL dir%0d_D got %h want %h", v, s_d, td[v]); end
                    n_checks++;
                    if (s_ovf !== to[v]) begin n_fail++; $display("FAIL dir%0d_ovf got %0b want %0b", v, s_ovf, to[v]); end
                end
            end
            exp_q.delete();
            exp_ovf_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        for (int t = 0; t < 28; t++) begin
            cyc(t < 24, W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b1);
            n_checks++;
            if (s_irdy !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready t=%0d got %0b want 1", t, s_irdy); end
            if (s_ovld) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_beat got %h want none", s_d);
                end else begin
                    logic [W:0] e; logic eo;
                    e = exp_q.pop_front(); eo = exp_ovf_q.pop_front(); got++;
                    if (s_d !== e || s_ovf !== eo) begin
                        n_fail++; $display("FAIL b2b_data got %h/%0b want %h/%0b", s_d, s_ovf, e, eo);
                    end
                end
            end
        end
        n_checks++;
        if (got != 24) begin n_fail++; $display("FAIL b2b_count got %0d want 24", got); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] oa[5], ob[5];
        logic         oc[5];
        logic [W:0]   held = '0;
        logic         prev_stall = 1'b0;
        int idx = 0, got = 0, t = 0;
        for (int i = 0; i < 5; i++) begin
            oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom);
        end
        while ((got < 5 || idx < 5) && t < 40) begin
            logic ordy;
            ordy = !(t >= 3 && t < 7);
            cyc(idx < 5, oa[idx % 5], ob[idx % 5], oc[idx % 5], ordy, 1'b1);
            if (idx < 5 && s_irdy) idx++;
            if (!ordy) begin
                n_checks++;
                if (s_ovld !== 1'b1 || s_irdy !== 1'b0) begin
                    n_fail++; $display("FAIL bp_stall t=%0d out_valid/in_ready got %0b/%0b want 1/0", t, s_ovld, s_irdy);
                end
                if (prev_stall) begin
                    n_checks++;
                    if (s_d !== held) begin n_fail++; $display("FAIL bp_D_stable got %h want %h", s_d, held); end
                end
                held = s_d;
            end
            prev_stall = !ordy;
            if (s_ovld && ordy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra_beat got %h want none", s_d);
                end else begin
                    logic [W:0] e; logic eo;
                    e = exp_q.pop_front(); eo = exp_ovf_q.pop_front(); got++;
                    if (s_d !== e || s_ovf !== eo) begin
                        n_fail++; $display("FAIL bp_data got %h/%0b want %h/%0b", s_d, s_ovf, e, eo);
                    end
                end
            end
            t++;
        end
        n_checks++;
        if (got != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", got); end
    endtask

    task automatic test_random_stall();
        int got = 0, sent = 0;
        for (int t = 0; t < 150; t++) begin
            logic iv, ordy;
            iv   = (t < 120) && ($urandom_range(0, 3) != 0);
            ordy = (t >= 120) || ($urandom_range(0, 2) != 0);
            cyc(iv, W'($urandom), W'($urandom), 1'($urandom), ordy, 1'b1);
            if (iv && s_irdy) sent++;
            n_checks++;
            if (s_irdy !== (ordy | ~s_ovld)) begin
                n_fail++; $display("FAIL rnd_in_ready got %0b want %0b", s_irdy, ordy | ~s_ovld);
            end
            if (s_ovld && ordy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra_beat got %h want none", s_d);
                end else begin
                    logic [W:0] e; logic eo;
                    e = exp_q.pop_front(); eo = exp_ovf_q.pop_front(); got++;
                    if (s_d !== e || s_ovf !== eo) begin
                        n_fail++; $display("FAIL rnd_data got %h/%0b want %h/%0b", s_d, s_ovf, e, eo);
                    end
                end
            end
        end
        n_checks++;
        if (got != sent) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", got, sent); end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, 1'b1);
        cyc(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        exp_q.delete();
        exp_ovf_q.delete();
        n_checks++;
        if (s_ovld !== 1'b0 || s_d !== '0) begin
            n_fail++; $display("FAIL rstmid_flush out_valid/D got %0b/%h want 0/0", s_ovld, s_d);
        end
        for (int t = 0; t < 8; t++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (s_ovld !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale t=%0d got %0b want 0", t, s_ovld); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subtractor16b_pipe.md
SUBTRACTOR16B_PIPE -- requirements
Module: subtractor16b_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are powers of two from 4 to 32.
REQ-002 SHALL have parameter LOG2W, default 4, number of Kogge-Stone prefix levels; it SHALL equal log2(WIDTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; it is synchronous and active-low.
REQ-005 SHALL have ports A and B, input, WIDTH, minuend and subtrahend (unsigned).
REQ-006 SHALL have port bin, input, 1, borrow-in.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the input handshake.
REQ-008 SHALL have port D, output, WIDTH+1, where D[WIDTH] is borrow-out and D[WIDTH-1:0] is the difference.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the output handshake.
REQ-010 SHALL have port ovf, output, 1, signed-overflow flag (see Configuration).

Function
REQ-011 Arithmetic SHALL satisfy D[WIDTH-1:0] = (A - B - bin) mod 2^WIDTH.
REQ-012 D[WIDTH] SHALL be 1 iff A < B + bin (unsigned).
REQ-013 The datapath SHALL compute A + ~B + ~bin with a Kogge-Stone prefix carry network; the borrow is the inverted carry-out.
REQ-014 The pipeline SHALL have 3 register stages: S1 holds the operands and bitwise g/p; S2 holds the result of prefix levels 1..ceil(LOG2W/2); S3 holds the remaining levels, the sum XOR, and the output register.
REQ-015 Latency SHALL be exactly 3 clk edges from an accepted input (in_valid & in_ready) to the matching out_valid, when there is no stall.
REQ-016 Advance condition: adv = out_ready | ~out_valid; all stages SHALL load together only when adv = 1.
REQ-017 in_ready SHALL equal adv, combinationally.
REQ-018 A stage valid bit SHALL propagate only when adv = 1, and bubbles are preserved; throughput is 1 result per cycle with out_ready held at 1.
REQ-019 While out_valid = 1 and out_ready = 0, D, ovf and out_valid SHALL remain stable.
REQ-020 An input presented with in_valid = 0 SHALL NOT create an output beat.
REQ-021 Results SHALL emerge in acceptance order, and no result SHALL be dropped or duplicated.

Reset
REQ-022 On rst_n = 0 at a clk edge, all stage valid bits, out_valid, D and ovf SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight operands, and no partial result SHALL appear after release.
REQ-024 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-025 When macro SUB16_SIGNED_OVF_EN is defined, ovf SHALL equal (A[MSB] != B[MSB]) & (D[MSB] != A[MSB]), aligned with D.
REQ-026 When SUB16_SIGNED_OVF_EN is undefined, ovf SHALL be tied to 0 and no overflow logic or registers SHALL be synthesized.

Structure
REQ-027 The shared package sub_pkg SHALL hold the following, used by both RTL and bench:
- the default WIDTH and LOG2W constants;
- the gp_t struct {g, p};
- the prefix combine function (g = g_hi | p_hi & g_lo; p = p_hi & p_lo).
REQ-028 There SHALL be one sub-module, ks_prefix_level, which implements a single prefix level at distance 2^k; it is instantiated LOG2W times across S2/S3.

Verification
REQ-029 Reset case: A=16'h1234, B=16'h0034, bin=0, out_ready=1 -> D=17'h01200 exactly 3 edges later, and out_valid pulses 1 cycle.
REQ-030 Wrap case: A=0, B=1, bin=0 -> D=17'h1FFFF (borrow=1).
REQ-031 Borrow-in case: A=16'hFFFF, B=16'hFFFF, bin=1 -> D=17'h1FFFF; with bin=0 -> D=17'h00000.
REQ-032 Backpressure case: stream 5 random operands, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the stall, D stable, and all 5 results in order matching the reference model.
REQ-033 Reset-mid-flight case: accept 2 operands, assert rst_n=0 for 1 cycle -> out_valid=0, and no stale result appears afterwards.
REQ-034 Overflow case, with SUB16_SIGNED_OVF_EN: A=16'h8000, B=16'h0001 -> D[15:0]=16'h7FFF and ovf=1; without the macro, ovf=0.
